// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem handshake and IF/ID register
module fetch_stage #(
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [15:0]         NOP_INSTR = 16'h0800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                imem_valid,
  output logic [15:0]         if_id_instr,
  output logic [PC_WIDTH-1:0] if_id_pc_plus2,
  output logic                if_id_valid,
  output logic                fetch_halted
);

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n, pending_pc, pending_pc_n;
  logic                halted_n;
  logic [PC_WIDTH-1:0] pc_plus2;

  assign pc_plus2  = pc + PC_WIDTH'(2);
  assign imem_addr = pc;
  assign imem_req  = !rst && (state != HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      pending_pc   <= '0;
      fetch_halted <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pending_pc   <= pending_pc_n;
      fetch_halted <= halted_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pending_pc_n = pending_pc;
    halted_n     = fetch_halted;
    case (state)
      FETCH: begin
        if (redirect) begin
          // Address may only change once the outstanding access has returned
          if (imem_valid) begin
            pc_n = redirect_pc;
          end else begin
            pending_pc_n = redirect_pc;
            state_n      = DRAIN;
          end
        end else if (!stall && imem_valid) begin
          pc_n = pc_plus2;
          if (imem_rdata[15:11] == 5'b00000) begin
            state_n  = HALTED;
            halted_n = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (redirect) pending_pc_n = redirect_pc;
        if (imem_valid) begin
          pc_n    = redirect ? redirect_pc : pending_pc;
          state_n = FETCH;
        end
      end
      HALTED: begin
        if (redirect) begin
          pc_n     = redirect_pc;
          halted_n = 1'b0;
          state_n  = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // IF/ID register: flush beats stall, stall beats fetch, otherwise bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
    end else if (redirect) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (state == FETCH && imem_valid) begin
        if_id_instr    <= imem_rdata;
        if_id_pc_plus2 <= pc_plus2;
        if_id_valid    <= 1'b1;
      end else begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule
